// File: rtl/truth_table_sweep.sv
// Walks the 3-bit vector {B,C,D} through 0..7, lets the stage under test settle,
// and captures its Y response into an 8-bit truth table checked against a golden one.
module truth_table_sweep #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    input  logic [7:0] expected_tt,
    output logic       b_out,
    output logic       c_out,
    output logic       d_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       result_valid,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] table_q, table_d;
    logic       valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            table_q <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    table_d = 8'h00;
                    valid_d = 1'b0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SettleLast) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                table_d[idx_q] = y_in;
                // The last vector ends the sweep instead of wrapping idx back to 0.
                if (idx_q != 3'd7) begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = 4'd0;
                    state_d = SETTLE;
                end else begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy         = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done         = (state_q == DONE);
    assign b_out        = busy & idx_q[2];
    assign c_out        = busy & idx_q[1];
    assign d_out        = busy & idx_q[0];
    assign table_out    = table_q;
    assign result_valid = valid_q;
    assign pass         = valid_q && (table_q == expected_tt);

endmodule

// File: tb/tb_truth_table_sweep.sv
// Drives two sweepers (default settle and SETTLE_CYCLES=1) against a modelled
// combinational stage and checks them cycle by cycle against a timing/table model.
module tb_truth_table_sweep;

    logic       clk;
    logic       rst_n;
    logic       startA, startB;
    logic       yA, yB;
    logic [7:0] expTt;
    logic [7:0] stageTt;
    logic       bA, cA, dA, busyA, doneA, validA, passA;
    logic       bB, cB, dB, busyB, doneB, validB, passB;
    logic [7:0] tableA, tableB;

    int dutSel;
    logic       obsB, obsC, obsD, obsBusy, obsDone, obsValid, obsPass;
    logic [7:0] obsTable;

    int passCount;
    int checkCount;

    truth_table_sweep dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .y_in(yA), .expected_tt(expTt),
        .b_out(bA), .c_out(cA), .d_out(dA), .busy(busyA), .done(doneA),
        .table_out(tableA), .result_valid(validA), .pass(passA)
    );

    truth_table_sweep #(.SETTLE_CYCLES(1)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .y_in(yB), .expected_tt(expTt),
        .b_out(bB), .c_out(cB), .d_out(dB), .busy(busyB), .done(doneB),
        .table_out(tableB), .result_valid(validB), .pass(passB)
    );

    // The stage under test is modelled as a lookup of its own truth table.
    assign yA = stageTt[{bA, cA, dA}];
    assign yB = stageTt[{bB, cB, dB}];

    always_comb begin
        if (dutSel == 1) begin
            obsB = bB; obsC = cB; obsD = dB; obsBusy = busyB; obsDone = doneB;
            obsValid = validB; obsPass = passB; obsTable = tableB;
        end else begin
            obsB = bA; obsC = cA; obsD = dA; obsBusy = busyA; obsDone = doneA;
            obsValid = validA; obsPass = passA; obsTable = tableA;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input logic [7:0] stage, input logic [7:0] golden);
        stageTt = stage;
        expTt   = golden;
    endtask

    task automatic setStart(input int sel, input logic v);
        if (sel == 1) startB = v;
        else startA = v;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_A"}, {bA, cA, dA, busyA, doneA, validA, passA, tableA}, 32'h0);
        checkOutput({tag, "_B"}, {bB, cB, dB, busyB, doneB, validB, passB, tableB}, 32'h0);
    endtask

    // Called at a negedge with the selected DUT idle; returns in IDLE after the sweep.
    task automatic runSweep(input int sel, input logic [7:0] stage, input logic [7:0] golden,
                            input bit holdStart, input bit pokeBusy);
        int settle;
        int total;
        int vec;
        logic [7:0] partial;
        logic [7:0] newGolden;
        settle = (sel == 1) ? 1 : 2;
        total  = 8 * (settle + 1);
        dutSel = sel;
        applyStimulus(stage, golden);
        setStart(sel, 1'b1);
        @(negedge clk);
        if (!holdStart) setStart(sel, 1'b0);
        for (int e = 0; e < total; e++) begin
            vec     = e / (settle + 1);
            partial = stage & 8'((1 << vec) - 1);
            checkOutput("busy", 32'(obsBusy), 32'd1);
            checkOutput("vector", 32'({obsB, obsC, obsD}), 32'(vec));
            checkOutput("doneLow", 32'(obsDone), 32'd0);
            checkOutput("validLow", 32'(obsValid), 32'd0);
            checkOutput("partialTable", 32'(obsTable), 32'(partial));
            if (pokeBusy && e == 2 * (settle + 1)) setStart(sel, 1'b1);
            else if (pokeBusy && e == 2 * (settle + 1) + 1) setStart(sel, 1'b0);
            @(negedge clk);
        end
        checkOutput("doneHigh", 32'(obsDone), 32'd1);
        checkOutput("busyInDone", 32'(obsBusy), 32'd0);
        checkOutput("vectorInDone", 32'({obsB, obsC, obsD}), 32'd0);
        checkOutput("validSet", 32'(obsValid), 32'd1);
        checkOutput("finalTable", 32'(obsTable), 32'(stage));
        checkOutput("pass", 32'(obsPass), 32'(stage == golden));
        @(negedge clk);
        checkOutput("donePulse", 32'(obsDone), 32'd0);
        checkOutput("idleBusy", 32'(obsBusy), 32'd0);
        checkOutput("validHeld", 32'(obsValid), 32'd1);
        checkOutput("tableHeld", 32'(obsTable), 32'(stage));
        newGolden = (($urandom & 1) != 0) ? stage : 8'($urandom);
        expTt = newGolden;
        #1;
        checkOutput("passFollows", 32'(obsPass), 32'(stage == newGolden));
    endtask

    logic [7:0] golden;
    logic [7:0] rndStage;
    logic [7:0] rndGolden;
    logic [2:0] v3;

    initial begin
        passCount  = 0;
        checkCount = 0;
        dutSel     = 0;
        startA     = 1'b0;
        startB     = 1'b0;
        stageTt    = 8'h00;
        expTt      = 8'h00;
        rst_n      = 1'b0;

        // Truth table of Y = ~C & D, indexed by vector {B,C,D}.
        for (int v = 0; v < 8; v++) begin
            v3 = 3'(v);
            golden[v] = ~v3[1] & v3[0];
        end

        repeat (3) @(negedge clk);
        checkAllZero("resetState");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idleAfterReset", 32'({busyA, validA, tableA}), 32'h0);

        $display("[TB] golden sweep");
        runSweep(0, golden, 8'h22, 1'b0, 1'b0);

        $display("[TB] fault detection");
        @(negedge clk);
        runSweep(0, 8'hFF, 8'h22, 1'b0, 1'b0);

        $display("[TB] settle of one");
        @(negedge clk);
        runSweep(1, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("[TB] start held high");
        @(negedge clk);
        runSweep(0, 8'h5A, 8'h5A, 1'b1, 1'b0);
        runSweep(0, 8'hC3, 8'h00, 1'b1, 1'b0);
        setStart(0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] start while busy");
        runSweep(0, golden, 8'h22, 1'b0, 1'b1);

        $display("[TB] reset mid-sweep");
        @(negedge clk);
        dutSel = 0;
        applyStimulus(golden, 8'h22);
        setStart(0, 1'b1);
        @(negedge clk);
        setStart(0, 1'b0);
        repeat (13) @(negedge clk);
        checkOutput("midSweepVector", 32'({bA, cA, dA}), 32'd4);
        #2 rst_n = 1'b0;
        #1 checkAllZero("asyncReset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("waitForStart", 32'({busyA, doneA, validA, tableA}), 32'h0);
        runSweep(0, golden, 8'h22, 1'b0, 1'b0);

        $display("[TB] random sweeps");
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            rndStage  = 8'($urandom);
            rndGolden = (($urandom & 1) != 0) ? rndStage : 8'($urandom);
            runSweep(r % 2, rndStage, rndGolden, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
